// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm bank: FSM states, LFSR seed/taps, slot record.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RING = 2'd1,
    ST_GAME = 2'd2
  } state_e;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic       on;
  } slot_t;

endpackage

// File: rtl/alarm_game.sv
// Dismissal mini-game: free-running LFSR target, answer arming, round counting.
// Answer evaluated on the clock it first turns non-zero; win_o is combinational for the parent FSM.
module alarm_game
  import alarm_pkg::*;
#(
  parameter int NUM_SW = 10,
  parameter int ROUNDS = 3
) (
  input  logic                         clk_osc,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         active_i,
  input  logic [NUM_SW-1:0]            game_sw_i,
  output logic [NUM_SW-1:0]            target_led_o,
  output logic [$clog2(ROUNDS+1)-1:0]  round_cnt_o,
  output logic                         win_o,
  output logic                         dismissed_o
);

  localparam int TW = $clog2(NUM_SW);
  localparam int CW = $clog2(ROUNDS+1);

  logic [7:0]        lfsr_q;
  logic [TW-1:0]     target_q;
  logic [TW-1:0]     target_d;
  logic [CW-1:0]     cnt_q;
  logic              armed_q;
  logic              dismissed_q;
  logic [NUM_SW-1:0] target_oh;
  logic              eval;
  logic              hit;
  int                t;

  always_comb begin
    t = int'(lfsr_q) % NUM_SW;
    // Never repeat the previous target back to back.
    if (t == int'(target_q)) t = (t + 1) % NUM_SW;
    target_d  = TW'(t);
    target_oh = NUM_SW'(1) << target_q;
    eval      = active_i && armed_q && (game_sw_i != '0);
    hit       = eval && (game_sw_i == target_oh);
    win_o     = hit && (cnt_q == CW'(ROUNDS - 1));
  end

  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= LFSR_SEED;
      target_q    <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      dismissed_q <= 1'b0;
    end else begin
      lfsr_q      <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
      armed_q     <= (game_sw_i == '0) || (armed_q && !eval);
      dismissed_q <= win_o;
      if (start_i) begin
        cnt_q    <= '0;
        target_q <= target_d;
      end else if (eval) begin
        cnt_q    <= hit ? cnt_q + CW'(1) : '0;
        target_q <= target_d;
      end
    end
  end

  assign target_led_o = active_i ? target_oh : '0;
  assign round_cnt_o  = cnt_q;
  assign dismissed_o  = dismissed_q;

endmodule

// File: rtl/alarm_bank.sv
// Alarm slots, time-match trigger, IDLE/RING/GAME FSM; outputs registered, writes land one clock later.
// Optional snooze (ALARM_SNOOZE_EN): btn_snooze in RING silences for SNOOZE_S ticks, then re-rings.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int NUM_SW     = 10,
  parameter int ROUNDS     = 3,
  parameter int SNOOZE_S   = 300
) (
  input  logic                           clk_osc,
  input  logic                           rst_n,
  input  logic                           tick_1hz,
  input  logic [4:0]                     cur_hour,
  input  logic [5:0]                     cur_min,
  input  logic [5:0]                     cur_sec,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_ALARMS)-1:0]  wr_slot,
  input  logic [4:0]                     wr_hour,
  input  logic [5:0]                     wr_min,
  input  logic                           wr_on,
  input  logic                           btn_start,
  input  logic                           btn_snooze,
  input  logic [NUM_SW-1:0]              game_sw,
  output logic                           ringing,
  output logic [$clog2(NUM_ALARMS)-1:0]  ring_slot,
  output logic                           game_active,
  output logic [NUM_SW-1:0]              target_led,
  output logic [$clog2(ROUNDS+1)-1:0]    round_cnt,
  output logic                           dismissed
);

  localparam int SW = $clog2(NUM_ALARMS);

  slot_t          slots_q [NUM_ALARMS];
  state_e         state_q;
  logic           ringing_q;
  logic [SW-1:0]  ring_slot_q;
  logic           game_active_q;
  logic           trig;
  logic [SW-1:0]  trig_idx;
  logic           game_start;
  logic           game_win;

  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) slots_q[i] <= '0;
    end else if (wr_en && (int'(wr_slot) < NUM_ALARMS)) begin
      slots_q[wr_slot] <= '{hour: wr_hour, min: wr_min, on: wr_on};
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    trig     = 1'b0;
    trig_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (tick_1hz && (cur_sec == 6'd0) && slots_q[i].on &&
          (slots_q[i].hour == cur_hour) && (slots_q[i].min == cur_min)) begin
        trig     = 1'b1;
        trig_idx = SW'(i);
      end
    end
  end

  assign game_start = (state_q == ST_RING) && btn_start;

`ifdef ALARM_SNOOZE_EN
  localparam int NW = $clog2(SNOOZE_S + 1);
  logic [NW-1:0] snz_q;
`else
  logic unused_snooze;
  assign unused_snooze = btn_snooze;
`endif

  always_ff @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ringing_q     <= 1'b0;
      ring_slot_q   <= '0;
      game_active_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_q         <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_q     <= ST_RING;
            ringing_q   <= 1'b1;
            ring_slot_q <= trig_idx;
`ifdef ALARM_SNOOZE_EN
            snz_q       <= '0;
          end else if (tick_1hz && (snz_q != '0)) begin
            snz_q <= snz_q - NW'(1);
            if (snz_q == NW'(1)) begin
              state_q   <= ST_RING;
              ringing_q <= 1'b1;
            end
`endif
          end
        end
        ST_RING: begin
          if (btn_start) begin
            state_q       <= ST_GAME;
            game_active_q <= 1'b1;
`ifdef ALARM_SNOOZE_EN
          end else if (btn_snooze) begin
            state_q   <= ST_IDLE;
            ringing_q <= 1'b0;
            snz_q     <= NW'(SNOOZE_S);
`endif
          end
        end
        ST_GAME: begin
          if (game_win) begin
            state_q       <= ST_IDLE;
            ringing_q     <= 1'b0;
            game_active_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  alarm_game #(
    .NUM_SW (NUM_SW),
    .ROUNDS (ROUNDS)
  ) u_game (
    .clk_osc      (clk_osc),
    .rst_n        (rst_n),
    .start_i      (game_start),
    .active_i     (state_q == ST_GAME),
    .game_sw_i    (game_sw),
    .target_led_o (target_led),
    .round_cnt_o  (round_cnt),
    .win_o        (game_win),
    .dismissed_o  (dismissed)
  );

  assign ringing     = ringing_q;
  assign ring_slot   = ring_slot_q;
  assign game_active = game_active_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank with an independent LFSR/target model; honours ALARM_SNOOZE_EN.
module tb_alarm_bank;

  localparam int NA  = 4;
  localparam int NSW = 10;
  localparam int NR  = 3;

  logic            clk_osc = 1'b0;
  logic            rst_n;
  logic            tick_1hz;
  logic [4:0]      cur_hour;
  logic [5:0]      cur_min;
  logic [5:0]      cur_sec;
  logic            wr_en;
  logic [1:0]      wr_slot;
  logic [4:0]      wr_hour;
  logic [5:0]      wr_min;
  logic            wr_on;
  logic            btn_start;
  logic            btn_snooze;
  logic [NSW-1:0]  game_sw;
  logic            ringing;
  logic [1:0]      ring_slot;
  logic            game_active;
  logic [NSW-1:0]  target_led;
  logic [1:0]      round_cnt;
  logic            dismissed;

  always #5 clk_osc = ~clk_osc;

  alarm_bank #(
    .NUM_ALARMS (NA),
    .NUM_SW     (NSW),
    .ROUNDS     (NR),
    .SNOOZE_S   (3)
  ) dut (
    .clk_osc     (clk_osc),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .cur_hour    (cur_hour),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .wr_en       (wr_en),
    .wr_slot     (wr_slot),
    .wr_hour     (wr_hour),
    .wr_min      (wr_min),
    .wr_on       (wr_on),
    .btn_start   (btn_start),
    .btn_snooze  (btn_snooze),
    .game_sw     (game_sw),
    .ringing     (ringing),
    .ring_slot   (ring_slot),
    .game_active (game_active),
    .target_led  (target_led),
    .round_cnt   (round_cnt),
    .dismissed   (dismissed)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, steps every clock out of reset.
  logic [7:0] m_lfsr;
  int         m_tgt;
  always @(posedge clk_osc or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nxt_tgt(input logic [7:0] l, input int prev);
    int t;
    t = int'(l) % NSW;
    if (t == prev) t = (t + 1) % NSW;
    return t;
  endfunction

  function automatic logic [NSW-1:0] oh(input int t);
    logic [NSW-1:0] r;
    r    = '0;
    r[t] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk_osc);
    @(negedge clk_osc);
  endtask

  task automatic tick_at(input int h, input int m, input int s);
    cur_hour = 5'(h);
    cur_min  = 6'(m);
    cur_sec  = 6'(s);
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic wr(input int slot, input int h, input int m, input logic on);
    wr_en   = 1'b1;
    wr_slot = 2'(slot);
    wr_hour = 5'(h);
    wr_min  = 6'(m);
    wr_on   = on;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    m_tgt     = nxt_tgt(m_lfsr, m_tgt);
    step();
    btn_start = 1'b0;
  endtask

  task automatic answer(input logic [NSW-1:0] sw);
    game_sw = sw;
    m_tgt   = nxt_tgt(m_lfsr, m_tgt);
    step();
  endtask

  task automatic release_sw();
    game_sw = '0;
    step();
  endtask

  logic [NSW-1:0] prior;

  initial begin
    tick_1hz = 0; cur_hour = 0; cur_min = 0; cur_sec = 0;
    wr_en = 0; wr_slot = 0; wr_hour = 0; wr_min = 0; wr_on = 0;
    btn_start = 0; btn_snooze = 0; game_sw = '0;
    m_tgt = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ringing", ringing, 0);
    chk("rst_ring_slot", ring_slot, 0);
    chk("rst_game_active", game_active, 0);
    chk("rst_target_led", target_led, 0);
    chk("rst_round_cnt", round_cnt, 0);
    chk("rst_dismissed", dismissed, 0);
    @(negedge clk_osc);
    rst_n = 1'b1;
    step();

    // Write lands while the time already matches: compare sees the old (off) slot.
    wr_en = 1; wr_slot = 2; wr_hour = 7; wr_min = 30; wr_on = 1;
    cur_hour = 7; cur_min = 30; cur_sec = 0; tick_1hz = 1;
    step();
    wr_en = 0; tick_1hz = 0;
    chk("old_slot_cmp", ringing, 0);
    tick_at(7, 30, 1);
    chk("sec_nonzero", ringing, 0);
    tick_at(7, 30, 0);
    chk("trig_ringing", ringing, 1);
    chk("trig_slot", ring_slot, 2);
    chk("ring_led_off", target_led, 0);
    wr(2, 7, 31, 1'b0);
    chk("rewrite_keeps_ring", ringing, 1);
    wr(2, 7, 30, 1'b1);

    // Start and snooze together: start wins.
    btn_snooze = 1'b1;
    press_start();
    btn_snooze = 1'b0;
    chk("start_game_active", game_active, 1);
    chk("start_ringing", ringing, 1);
    chk("start_round", round_cnt, 0);
    chk("start_target", target_led, oh(m_tgt));

    for (int r = 1; r <= 2; r++) begin
      answer(oh(m_tgt));
      chk("correct_round", round_cnt, r);
      chk("correct_target", target_led, oh(m_tgt));
      release_sw();
    end
    prior = oh(m_tgt);
    answer(oh((m_tgt + 1) % NSW));
    chk("wrong_round", round_cnt, 0);
    chk("wrong_target", target_led, oh(m_tgt));
    chk("wrong_tgt_differs", target_led != prior, 1);
    release_sw();
    answer(oh(m_tgt));
    chk("after_wrong_round", round_cnt, 1);
    // Jump straight to the new correct switch without releasing: not armed.
    game_sw = oh(m_tgt);
    step(); step(); step();
    chk("hold_no_count", round_cnt, 1);
    chk("hold_same_target", target_led, oh(m_tgt));
    release_sw();
    answer(oh(m_tgt));
    chk("round2", round_cnt, 2);
    release_sw();
    answer(oh(m_tgt));
    chk("round3", round_cnt, 3);
    chk("dismiss_pulse", dismissed, 1);
    chk("dismiss_ringing", ringing, 0);
    chk("dismiss_game_active", game_active, 0);
    chk("dismiss_led", target_led, 0);
    step();
    chk("dismiss_one_cycle", dismissed, 0);
    release_sw();

    // Slot stays enabled after dismissal.
    tick_at(7, 30, 0);
    chk("daily_ringing", ringing, 1);
    chk("daily_slot", ring_slot, 2);

    btn_snooze = 1'b1;
    step();
    btn_snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
    chk("snooze_silent", ringing, 0);
    tick_at(12, 0, 0);
    tick_at(12, 0, 0);
    chk("snooze_2ticks", ringing, 0);
    tick_at(12, 0, 0);
    chk("snooze_rering", ringing, 1);
    chk("snooze_slot", ring_slot, 2);
`else
    chk("snooze_ignored", ringing, 1);
`endif

    // Triggers outside IDLE are dropped.
    wr(1, 6, 0, 1'b1);
    wr(3, 6, 0, 1'b1);
    tick_at(6, 0, 0);
    chk("ring_drops_trig", ring_slot, 2);
    press_start();
    chk("game2_active", game_active, 1);
    answer(oh(m_tgt));
    chk("game2_round", round_cnt, 1);

    // Asynchronous reset mid-game.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ringing", ringing, 0);
    chk("arst_game_active", game_active, 0);
    chk("arst_led", target_led, 0);
    chk("arst_round", round_cnt, 0);
    chk("arst_slot", ring_slot, 0);
    chk("arst_dismissed", dismissed, 0);
    @(negedge clk_osc);
    rst_n   = 1'b1;
    m_tgt   = 0;
    game_sw = '0;
    step();
    chk("post_rst_dismissed", dismissed, 0);
    tick_at(7, 30, 0);
    chk("slot2_cleared", ringing, 0);
    tick_at(6, 0, 0);
    chk("slot13_cleared", ringing, 0);

    wr(1, 6, 0, 1'b1);
    wr(3, 6, 0, 1'b1);
    tick_at(6, 0, 0);
    chk("prio_ringing", ringing, 1);
    chk("prio_slot", ring_slot, 1);
    press_start();
    chk("game3_active", game_active, 1);
    chk("game3_round", round_cnt, 0);
    chk("game3_target", target_led, oh(m_tgt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_bank.md
ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 The block SHALL expose parameter NUM_ALARMS, default 4, as the number of independent alarm slots (2..8).
REQ-002 The block SHALL expose parameter NUM_SW, default 10, as the number of mini-game switches (2..14).
REQ-003 The block SHALL expose parameter ROUNDS, default 3, as the number of consecutive correct answers needed to dismiss.
REQ-004 The block SHALL expose parameter SNOOZE_S, default 300, as the snooze length in seconds.
REQ-005 The block SHALL have port clk_osc, input, width 1: the single clock; all flops on its rising edge.
REQ-006 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port tick_1hz, input, width 1: one-cycle pulse per second.
REQ-008 The block SHALL have ports cur_hour, cur_min and cur_sec, inputs, widths 5/6/6: current time in BCD-free binary.
REQ-009 The block SHALL have ports wr_en (1), wr_slot (clog2 NUM_ALARMS), wr_hour (5), wr_min (6) and wr_on (1), all inputs: slot write.
REQ-010 The block SHALL have ports btn_start and btn_snooze, inputs, width 1: debounced single-cycle pulses.
REQ-011 The block SHALL have port game_sw, input, width NUM_SW: synchronised switch levels.
REQ-012 The block SHALL have outputs ringing (1), ring_slot (clog2 NUM_ALARMS), game_active (1), target_led (NUM_SW), round_cnt (clog2 ROUNDS+1) and dismissed (1, one-cycle pulse).

Function
REQ-013 Slot write SHALL take effect on the clock after wr_en; the compare in that same cycle SHALL use the old slot value.
REQ-014 The trigger SHALL require: tick_1hz=1, cur_sec=0, and the slot's on=1 with hour/min equal to cur_hour/cur_min; the lowest matching index wins.
REQ-015 The FSM SHALL have states IDLE, RING and GAME; the trigger SHALL be honoured only in IDLE, with other triggers dropped.
REQ-016 In IDLE on a trigger: go to RING, ringing=1, ring_slot=index.
REQ-017 In RING on btn_start: go to GAME, round_cnt=0, load a new target.
REQ-018 The target SHALL be lfsr mod NUM_SW, where lfsr is 8-bit (x^8+x^6+x^5+x^4+1), seed 8'hA5, advancing every clock; if the result equals the previous target, (t+1) mod NUM_SW SHALL be used instead.
REQ-019 In GAME, target_led SHALL be one-hot at the target; target_led SHALL be 0 in all other states.
REQ-020 An answer SHALL be evaluated only when armed (armed is set when game_sw==0); evaluation happens when game_sw first becomes non-zero.
REQ-021 For an answer equal to the one-hot target: round_cnt+1 and a new target; if round_cnt reaches ROUNDS: one-cycle dismissed pulse, ringing=0, go to IDLE.
REQ-022 For any other non-zero answer: round_cnt=0 and a new target.
REQ-023 ringing SHALL stay 1 throughout GAME; game_active=1 only in GAME.
REQ-024 Rewriting the ringing slot SHALL NOT stop ringing.
REQ-025 btn_start and btn_snooze asserted together SHALL give btn_start priority.
REQ-026 Dismissal SHALL leave the slot's on bit set, so the alarm is daily.

Reset
REQ-027 While rst_n=0: all slots cleared to 00:00 with on=0; FSM=IDLE; lfsr=8'hA5; all outputs 0; snooze counter 0; armed=0.
REQ-028 Reset asserted mid-GAME SHALL abort immediately with no dismissed pulse.

Configuration
REQ-029 With ALARM_SNOOZE_EN defined: btn_snooze in RING → IDLE, ringing=0, counter=SNOOZE_S, decremented on tick_1hz; at 0, re-enter RING with the same ring_slot; btn_snooze in GAME ignored.
REQ-030 With ALARM_SNOOZE_EN defined: a new trigger while snoozing cancels the snooze.
REQ-031 Without ALARM_SNOOZE_EN: the btn_snooze port SHALL exist but be ignored, and no counter SHALL be synthesised.

Structure
REQ-032 Package alarm_pkg SHALL hold the state enum, the LFSR seed/taps constant and the slot record type (hour, min, on).
REQ-033 Sub-module alarm_game SHALL implement the LFSR, target, armed and round logic; alarm_bank SHALL hold the slots, trigger, FSM and snooze.

Verification
REQ-034 Write slot 2 = 07:30 on; drive 07:30:00 with a tick → next clock ringing=1, ring_slot=2.
REQ-035 Slots 1 and 3 both 06:00 on → at the trigger ring_slot=1; slot 3 dropped.
REQ-036 btn_start, then three correct one-hot answers with game_sw returned to 0 between them → round_cnt 1,2,3, then dismissed pulse, ringing=0, state IDLE.
REQ-037 In GAME after round 2, a wrong switch → round_cnt=0 and target differs from the prior target; holding a correct switch without release → no further count.
REQ-038 With ALARM_SNOOZE_EN and SNOOZE_S=3: btn_snooze → ringing=0, then after 3 ticks ringing=1 with the same slot; without the macro, btn_snooze → ringing stays 1.
REQ-039 rst_n pulsed low in GAME → all outputs 0 asynchronously; slot on bits 0; no dismissed pulse.
